// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/EXT shared memory port arbiter with read-latency insertion
// Optional MEM_ARB_STATS_EN adds saturating conflict / EXT-wait counters.
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int RD_LAT        = 1,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_conflicts,
    output logic [15:0]   stat_ext_wait
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t     state;
    logic       owner;
    logic [3:0] burst_cnt;
    logic [2:0] wait_cnt;

    logic burst_full;
    logic grant_cpu;
    logic grant_ext;

    // CPU wins ties until it has taken MAX_CPU_BURST grants in a row over a waiting EXT.
    always_comb begin
        burst_full = (burst_cnt == 4'(MAX_CPU_BURST));
        grant_cpu  = cpu_req && !(ext_req && burst_full);
        grant_ext  = ext_req && !grant_cpu;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            burst_cnt <= 4'd0;
            wait_cnt  <= 3'd0;
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ext_ack <= 1'b0;
            mem_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ext_req) begin
                        burst_cnt <= 4'd0;
                    end
                    if (grant_cpu || grant_ext) begin
                        owner     <= grant_ext;
                        mem_we    <= grant_ext ? ext_we    : cpu_we;
                        mem_addr  <= grant_ext ? ext_addr  : cpu_addr;
                        mem_wdata <= grant_ext ? ext_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                        if (grant_ext) begin
                            burst_cnt <= 4'd0;
                        end else if (ext_req) begin
                            burst_cnt <= 4'(burst_cnt + 4'd1);
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        state   <= ACK;
                        cpu_ack <= !owner;
                        ext_ack <= owner;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 3'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        rdata   <= mem_rdata;
                        state   <= ACK;
                        cpu_ack <= !owner;
                        ext_ack <= owner;
                    end else begin
                        wait_cnt <= 3'(wait_cnt - 3'd1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    // EXT counts as waiting whenever it requests and is not the owner of an access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conflicts <= 16'd0;
            stat_ext_wait  <= 16'd0;
        end else begin
            if (state == IDLE && cpu_req && ext_req && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
            if (ext_req && !(state != IDLE && owner) && stat_ext_wait != 16'hFFFF) begin
                stat_ext_wait <= stat_ext_wait + 16'd1;
            end
        end
    end
`endif

endmodule
